// File: rtl/kat_tge_tx_arbiter_if.sv
// Requester and core-side buses of the TGE transmit arbiter.
// The arbiter connects through the master modport; the requesters and core side use the slave modport.
`timescale 1ns/1ps
interface kat_tge_tx_arbiter_if #(
    parameter int N_PORTS = 4
);
    logic [N_PORTS-1:0]    req_valid;
    logic [N_PORTS-1:0]    grant;
    logic [N_PORTS-1:0]    in_valid;
    logic [N_PORTS-1:0]    in_eof;
    logic [64*N_PORTS-1:0] in_data;
    logic [32*N_PORTS-1:0] in_dest_ip;
    logic [16*N_PORTS-1:0] in_dest_port;
    logic                  tx_valid;
    logic                  tx_end_of_frame;
    logic [63:0]           tx_data;
    logic [31:0]           tx_dest_ip;
    logic [15:0]           tx_dest_port;
    logic                  tx_afull;
    logic                  tx_overflow;

    modport master (
        input  req_valid, in_valid, in_eof, in_data, in_dest_ip, in_dest_port,
        input  tx_afull, tx_overflow,
        output grant, tx_valid, tx_end_of_frame, tx_data, tx_dest_ip, tx_dest_port
    );

    modport slave (
        output req_valid, in_valid, in_eof, in_data, in_dest_ip, in_dest_port,
        output tx_afull, tx_overflow,
        input  grant, tx_valid, tx_end_of_frame, tx_data, tx_dest_ip, tx_dest_port
    );
endinterface

// File: rtl/kat_tge_tx_arbiter.sv
// Frame-granular round-robin arbiter muxing N_PORTS word streams onto one TGE transmit port,
// with runaway-frame truncation and saturating truncation/overflow counters.
`timescale 1ns/1ps
module kat_tge_tx_arbiter #(
    parameter int N_PORTS         = 4,
    parameter int MAX_FRAME_WORDS = 1024,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    kat_tge_tx_arbiter_if.master bus,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] trunc_count,
    output logic [CNT_WIDTH-1:0] ovf_count
);
    localparam int IDX_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int WCNT_W = $clog2(MAX_FRAME_WORDS);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MAX_FRAME_WORDS - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_PORTS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_DRAIN} state_e;

    state_e               state_q, state_d;
    logic [N_PORTS-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
    logic                 txv_q, txv_d;
    logic                 txeof_q, txeof_d;
    logic [63:0]          txdata_q, txdata_d;
    logic [31:0]          txip_q, txip_d;
    logic [15:0]          txport_q, txport_d;
    logic [CNT_WIDTH-1:0] trunc_q, trunc_d;
    logic [CNT_WIDTH-1:0] ovf_q, ovf_d;
    logic                 ovf_prev_q;

    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic                 acc;
    logic                 acc_eof;

    // Round-robin search starting just after the last granted port.
    always_comb begin
        int cand;
        cand       = 0;
        pick_found = 1'b0;
        pick_idx   = last_q;
        for (int k = 1; k <= N_PORTS; k++) begin
            cand = int'(last_q) + k;
            if (cand >= N_PORTS) cand = cand - N_PORTS;
            if (!pick_found && bus.req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    assign acc     = bus.in_valid[last_q];
    assign acc_eof = acc && bus.in_eof[last_q];

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        wcnt_d   = wcnt_q;
        txv_d    = 1'b0;
        txeof_d  = 1'b0;
        txdata_d = txdata_q;
        txip_d   = txip_q;
        txport_d = txport_q;
        trunc_d  = trunc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_found && !bus.tx_afull) begin
                    grant_d = N_PORTS'(1) << pick_idx;
                    last_d  = pick_idx;
                    wcnt_d  = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (acc) begin
                    txv_d    = 1'b1;
                    txdata_d = bus.in_data[64*int'(last_q) +: 64];
                    txip_d   = bus.in_dest_ip[32*int'(last_q) +: 32];
                    txport_d = bus.in_dest_port[16*int'(last_q) +: 16];
                    wcnt_d   = wcnt_q + 1'b1;
                    if (acc_eof) begin
                        txeof_d = 1'b1;
                        grant_d = '0;
                        state_d = ST_IDLE;
                    end else if (wcnt_q == WCNT_LAST) begin
                        // Runaway frame: close it towards the core, swallow the rest.
                        txeof_d = 1'b1;
                        if (trunc_q != '1) trunc_d = trunc_q + 1'b1;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (acc_eof) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (bus.tx_overflow && !ovf_prev_q && ovf_q != '1) ovf_d = ovf_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            last_q     <= IDX_LAST;
            wcnt_q     <= '0;
            txv_q      <= 1'b0;
            txeof_q    <= 1'b0;
            txdata_q   <= '0;
            txip_q     <= '0;
            txport_q   <= '0;
            trunc_q    <= '0;
            ovf_q      <= '0;
            ovf_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            wcnt_q     <= wcnt_d;
            txv_q      <= txv_d;
            txeof_q    <= txeof_d;
            txdata_q   <= txdata_d;
            txip_q     <= txip_d;
            txport_q   <= txport_d;
            trunc_q    <= trunc_d;
            ovf_q      <= ovf_d;
            ovf_prev_q <= bus.tx_overflow;
        end
    end

    assign bus.grant           = grant_q;
    assign bus.tx_valid        = txv_q;
    assign bus.tx_end_of_frame = txeof_q;
    assign bus.tx_data         = txdata_q;
    assign bus.tx_dest_ip      = txip_q;
    assign bus.tx_dest_port    = txport_q;
    assign busy                = (state_q != ST_IDLE);
    assign trunc_count         = trunc_q;
    assign ovf_count           = ovf_q;
endmodule
